// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared constants for the eight-channel step-pulse generator
package motor_pkg;

    localparam int N_CH   = 8;
    localparam int PEND_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/motor_pls_chan.sv
// rtl/motor_pls_chan.sv - one step-pulse channel: synchronisers, edge detect, timing FSM, optional pending queue
// Optional request queue enabled by defining MOTOR_PLS_QUEUE_EN.
module motor_pls_chan
    import motor_pkg::*;
#(
    parameter int PLS_HIGH = 50,
    parameter int PLS_LOW  = 50,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic enable,
    output logic pls,
    output logic busy,
    output logic overrun
);

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(PLS_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(PLS_LOW - 1);

    logic [2:0]       pls_sync;
    logic [1:0]       en_sync;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             en;
    logic             terminal;
    logic             have_pend;
    logic             queue_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pls_sync <= '0;
            en_sync  <= '0;
        end else begin
            pls_sync <= {pls_sync[1:0], strobe};
            en_sync  <= {en_sync[0], enable};
        end
    end

    assign req      = pls_sync[1] & ~pls_sync[2];
    assign en       = en_sync[1];
    assign terminal = (state == ST_LOW) && (cnt == '0);

`ifdef MOTOR_PLS_QUEUE_EN
    logic [PEND_W-1:0] pending;

    assign have_pend  = (pending != '0);
    assign queue_full = &pending;

    // A dequeue and a new request in the same terminal cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (!en) begin
            pending <= '0;
        end else if (terminal && have_pend) begin
            if (!req) pending <= pending - 1'b1;
        end else if (req && (state != ST_IDLE) && !terminal && !queue_full) begin
            pending <= pending + 1'b1;
        end
    end
`else
    assign have_pend  = 1'b0;
    assign queue_full = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else if (!en) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            if (req && (state != ST_IDLE) && !terminal && queue_full)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_HIGH;
                        cnt   <= HIGH_LOAD;
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        state <= ST_LOW;
                        cnt   <= LOW_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt == '0) begin
                        if (have_pend || req) begin
                            state <= ST_HIGH;
                            cnt   <= HIGH_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign pls  = (state == ST_HIGH);
    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/motor_pls_gen.sv
// rtl/motor_pls_gen.sv - eight independent step-pulse channels fed by asynchronous strobes and enables
// Optional request queue enabled by defining MOTOR_PLS_QUEUE_EN.
module motor_pls_gen
    import motor_pkg::*;
#(
    parameter int PLS_HIGH = 50,
    parameter int PLS_LOW  = 50,
    parameter int CNT_W    = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [N_CH-1:0] gStateCmd,
    input  logic [N_CH-1:0] gPlsCmd,
    output logic [N_CH-1:0] MotorPls,
    output logic [N_CH-1:0] MotorBusy,
    output logic [N_CH-1:0] PlsOverrun
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        motor_pls_chan #(
            .PLS_HIGH (PLS_HIGH),
            .PLS_LOW  (PLS_LOW),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (nRST),
            .strobe  (gPlsCmd[g]),
            .enable  (gStateCmd[g]),
            .pls     (MotorPls[g]),
            .busy    (MotorBusy[g]),
            .overrun (PlsOverrun[g])
        );
    end

endmodule
